// File: rtl/psram_pkg.sv
// Shared definitions for the QPI PSRAM responder: opcodes, FSM encodings and bus address width.
package psram_pkg;
    localparam int ADDR_W = 24;

    localparam logic [7:0] CMD_QPI_EN   = 8'h35;
    localparam logic [7:0] CMD_QREAD    = 8'hEB;
    localparam logic [7:0] CMD_QWRITE   = 8'h38;
    localparam logic [7:0] CMD_QPI_EXIT = 8'hF5;

    typedef logic [2:0] state_t;

    localparam state_t ST_CMD    = 3'd0;
    localparam state_t ST_ADDR   = 3'd1;
    localparam state_t ST_DUMMY  = 3'd2;
    localparam state_t ST_RDATA  = 3'd3;
    localparam state_t ST_WDATA  = 3'd4;
    localparam state_t ST_IGNORE = 3'd5;
endpackage

// File: rtl/psram_qpi_responder_in_sync.sv
// Synchronises the initiator's sck/ce_n/din into clk_i and flags sck rise/fall and ce_n rise.
module psram_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] din,
    output logic       ce_n_s,
    output logic [3:0] din_s,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       ce_rise
);
    logic [SYNC_STAGES-1:0]      sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0]      ce_sync_q, ce_sync_d;
    logic [SYNC_STAGES-1:0][3:0] din_sync_q, din_sync_d;
    logic                        sck_prev_q, sck_prev_d;
    logic                        ce_prev_q, ce_prev_d;

    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
        ce_sync_d  = {ce_sync_q[SYNC_STAGES-2:0], ce_n};
        din_sync_d = {din_sync_q[SYNC_STAGES-2:0], din};
        sck_prev_d = sck_sync_q[SYNC_STAGES-1];
        ce_prev_d  = ce_sync_q[SYNC_STAGES-1];
    end

    // ce_n idles high so the chain resets to 1 to avoid a false ce_n rise after reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sync_q <= '0;
            ce_sync_q  <= '1;
            din_sync_q <= '0;
            sck_prev_q <= 1'b0;
            ce_prev_q  <= 1'b1;
        end else begin
            sck_sync_q <= sck_sync_d;
            ce_sync_q  <= ce_sync_d;
            din_sync_q <= din_sync_d;
            sck_prev_q <= sck_prev_d;
            ce_prev_q  <= ce_prev_d;
        end
    end

    assign ce_n_s   = ce_sync_q[SYNC_STAGES-1];
    assign din_s    = din_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
    assign ce_rise  = ce_n_s & ~ce_prev_q;
endmodule

// File: rtl/psram_qpi_responder.sv
// Device-side QPI PSRAM responder: decodes 35h/EBh/38h/F5h and bridges to a byte-wide memory port.
// state     | meaning
// ST_CMD    | shifting in the command (8 SPI bits or 2 QPI nibbles)
// ST_ADDR   | shifting in 6 address nibbles
// ST_DUMMY  | counting dummy rises while the first read byte is fetched
// ST_RDATA  | driving read nibbles on sck fall
// ST_WDATA  | assembling write bytes from nibble pairs
// ST_IGNORE | unsupported or finished command, wait for ce_n high
module psram_qpi_responder
    import psram_pkg::*;
#(
    parameter int MEM_AW       = 22,
    parameter int DUMMY_CYCLES = 6,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sck,
    input  logic              ce_n,
    input  logic [3:0]        din,
    output logic [3:0]        dout,
    output logic [3:0]        douten,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              qpi_mode
);
    localparam int CNT_W = 8;

    logic       ce_n_s, sck_rise, sck_fall, ce_rise;
    logic [3:0] din_s;

    psram_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_in_sync (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sck      (sck),
        .ce_n     (ce_n),
        .din      (din),
        .ce_n_s   (ce_n_s),
        .din_s    (din_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ce_rise  (ce_rise)
    );

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        cmd_q, cmd_d, shift_q, shift_d, mem_wdata_q, mem_wdata_d;
    logic [MEM_AW-1:0] addr_q, addr_d, addr_inc, mem_addr_q, mem_addr_d;
    logic [3:0]        lo_q, lo_d, wnib_q, wnib_d, dout_q, dout_d, douten_q, douten_d;
    logic              nib_hi_q, nib_hi_d, whalf_q, whalf_d, load_q, load_d;
    logic              qpi_q, qpi_d, pend_en_q, pend_en_d, pend_ex_q, pend_ex_d;
    logic              mem_re_q, mem_re_d, mem_we_q, mem_we_d;

    assign addr_inc = addr_q + MEM_AW'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        lo_d        = lo_q;
        wnib_d      = wnib_q;
        dout_d      = dout_q;
        douten_d    = douten_q;
        nib_hi_d    = nib_hi_q;
        whalf_d     = whalf_q;
        load_d      = mem_re_q;
        qpi_d       = qpi_q;
        pend_en_d   = pend_en_q;
        pend_ex_d   = pend_ex_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (load_q) shift_d = mem_rdata;

        // ce_n high overrides everything, including an sck edge seen in the same cycle
        if (ce_n_s) begin
            if (ce_rise && pend_en_q) qpi_d = 1'b1;
            if (ce_rise && pend_ex_q) qpi_d = 1'b0;
            pend_en_d = 1'b0;
            pend_ex_d = 1'b0;
            state_d   = ST_CMD;
            cnt_d     = qpi_d ? CNT_W'(1) : CNT_W'(7);
            douten_d  = 4'h0;
            nib_hi_d  = 1'b1;
            whalf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_CMD: if (sck_rise) begin
                    cmd_d = qpi_q ? {cmd_q[3:0], din_s} : {cmd_q[6:0], din_s[0]};
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (!qpi_q) begin
                        pend_en_d = (cmd_d == CMD_QPI_EN);
                        state_d   = ST_IGNORE;
                    end else if (cmd_d == CMD_QREAD || cmd_d == CMD_QWRITE) begin
                        state_d = ST_ADDR;
                        cnt_d   = CNT_W'(ADDR_W / 4 - 1);
                    end else begin
                        pend_ex_d = (cmd_d == CMD_QPI_EXIT);
                        state_d   = ST_IGNORE;
                    end
                end
                ST_ADDR: if (sck_rise) begin
                    addr_d = MEM_AW'({addr_q, din_s});
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (cmd_q == CMD_QREAD) begin
                        state_d    = ST_DUMMY;
                        cnt_d      = CNT_W'(DUMMY_CYCLES - 1);
                        mem_re_d   = 1'b1;
                        mem_addr_d = addr_d;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end
                ST_DUMMY: if (sck_rise) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d  = ST_RDATA;
                        nib_hi_d = 1'b1;
                    end
                end
                // low nibble is parked in lo_q so the prefetch can overwrite shift_q
                ST_RDATA: if (sck_fall) begin
                    douten_d = 4'hF;
                    if (nib_hi_q) begin
                        dout_d     = shift_q[7:4];
                        lo_d       = shift_q[3:0];
                        addr_d     = addr_inc;
                        mem_re_d   = 1'b1;
                        mem_addr_d = addr_inc;
                        nib_hi_d   = 1'b0;
                    end else begin
                        dout_d   = lo_q;
                        nib_hi_d = 1'b1;
                    end
                end
                ST_WDATA: if (sck_rise) begin
                    if (!whalf_q) begin
                        wnib_d  = din_s;
                        whalf_d = 1'b1;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = {wnib_q, din_s};
                        mem_addr_d  = addr_q;
                        addr_d      = addr_inc;
                        whalf_d     = 1'b0;
                    end
                end
                ST_IGNORE: ;
                default: state_d = ST_CMD;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_CMD;
            cnt_q       <= CNT_W'(7);
            cmd_q       <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            lo_q        <= '0;
            wnib_q      <= '0;
            dout_q      <= '0;
            douten_q    <= '0;
            nib_hi_q    <= 1'b1;
            whalf_q     <= 1'b0;
            load_q      <= 1'b0;
            qpi_q       <= 1'b0;
            pend_en_q   <= 1'b0;
            pend_ex_q   <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            lo_q        <= lo_d;
            wnib_q      <= wnib_d;
            dout_q      <= dout_d;
            douten_q    <= douten_d;
            nib_hi_q    <= nib_hi_d;
            whalf_q     <= whalf_d;
            load_q      <= load_d;
            qpi_q       <= qpi_d;
            pend_en_q   <= pend_en_d;
            pend_ex_q   <= pend_ex_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign dout      = dout_q;
    assign douten    = douten_q;
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign qpi_mode  = qpi_q;
endmodule

// File: tb/tb_psram_qpi_responder.sv
// Bench for psram_qpi_responder: drives SPI/QPI transactions and scoreboards memory strobes and read nibbles.
module tb_psram_qpi_responder;
    import psram_pkg::*;

    localparam int MEM_AW       = 22;
    localparam int DUMMY_CYCLES = 6;
    localparam int SYNC_STAGES  = 2;

    logic              clk_i = 1'b0;
    logic              rst_i, sck, ce_n;
    logic [3:0]        din, dout, douten;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_re, mem_we, qpi_mode;
    logic [7:0]        mem_rdata = 8'h00;
    logic [7:0]        mem_wdata;

    logic [7:0]          mem [0:(1<<MEM_AW)-1];
    logic [MEM_AW+7:0]   exp_wr_q[$], obs_wr_q[$];
    logic [MEM_AW-1:0]   exp_re_q[$], obs_re_q[$];
    logic [7:0]          exp_nib_q[$], obs_nib_q[$];
    logic                obs_oe_q[$], obs_clash_q[$];
    logic                dummy_leak;
    logic [3:0]          post_douten;
    int                  n_chk = 0;
    int                  n_fail = 0;

    psram_qpi_responder #(
        .MEM_AW(MEM_AW), .DUMMY_CYCLES(DUMMY_CYCLES), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sck(sck), .ce_n(ce_n), .din(din),
        .dout(dout), .douten(douten), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata), .qpi_mode(qpi_mode)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (mem_we) obs_wr_q.push_back({mem_addr, mem_wdata});
            if (mem_re) obs_re_q.push_back(mem_addr);
            if (douten != 4'h0) obs_oe_q.push_back(1'b1);
            if (mem_re && mem_we) obs_clash_q.push_back(1'b1);
        end
    end

    task automatic sck_cycle(input logic [3:0] d);
        din = d;
        #40 sck = 1'b1;
        #40 sck = 1'b0;
        #40;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]});
    endtask

    task automatic qpi_byte(input logic [7:0] b);
        sck_cycle(b[7:4]);
        sck_cycle(b[3:0]);
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) sck_cycle(a[i*4 +: 4]);
    endtask

    task automatic cs_begin();
        ce_n = 1'b0;
        #40;
    endtask

    task automatic cs_end();
        ce_n = 1'b1;
        #120;
    endtask

    // Expected strobes follow from the requested address: bytes land at consecutive addresses mod 2^MEM_AW.
    task automatic write_xact(input logic [23:0] a, input logic [31:0] data, input int n);
        logic [MEM_AW-1:0] wa;
        wa = a[MEM_AW-1:0];
        for (int i = 0; i < n; i++) exp_wr_q.push_back({wa + MEM_AW'(i), data[31-8*i -: 8]});
        cs_begin();
        qpi_byte(CMD_QWRITE);
        send_addr(a);
        for (int i = 0; i < n; i++) qpi_byte(data[31-8*i -: 8]);
        cs_end();
    endtask

    task automatic read_xact(input logic [23:0] a, input int nnib);
        obs_nib_q.delete();
        dummy_leak = 1'b0;
        cs_begin();
        qpi_byte(CMD_QREAD);
        send_addr(a);
        for (int d = 1; d <= DUMMY_CYCLES; d++) begin
            sck_cycle(4'h0);
            if (d < DUMMY_CYCLES && douten != 4'h0) dummy_leak = 1'b1;
        end
        obs_nib_q.push_back({douten, dout});
        for (int j = 1; j < nnib; j++) begin
            sck_cycle(4'h0);
            obs_nib_q.push_back({douten, dout});
        end
        // final rise samples the last nibble; ce_n rises before sck falls so no extra nibble is driven
        din = 4'h0;
        #40 sck = 1'b1;
        #40 ce_n = 1'b1;
        #40 sck = 1'b0;
        #80;
        post_douten = douten;
    endtask

    task automatic test_reset();
        n_chk++; if (qpi_mode !== 1'b0) begin n_fail++; $display("FAIL reset_qpi: got %b want 0", qpi_mode); end
        n_chk++; if (douten !== 4'h0) begin n_fail++; $display("FAIL reset_douten: got %h want 0", douten); end
        n_chk++; if (dout !== 4'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
        n_chk++; if ({mem_re, mem_we} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {mem_re, mem_we}); end
        n_chk++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_chk++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    endtask

    task automatic test_qpi_enter();
        obs_oe_q.delete();
        cs_begin();
        spi_byte(CMD_QPI_EN);
        n_chk++; if (qpi_mode !== 1'b0) begin n_fail++; $display("FAIL enter_before_ce: got %b want 0", qpi_mode); end
        cs_end();
        n_chk++; if (qpi_mode !== 1'b1) begin n_fail++; $display("FAIL enter_qpi: got %b want 1", qpi_mode); end
        n_chk++; if (obs_oe_q.size() != 0) begin n_fail++; $display("FAIL enter_douten: got %0d enabled cycles want 0", obs_oe_q.size()); end
    endtask

    task automatic check_writes(input string name);
        n_chk++;
        if (obs_wr_q.size() != exp_wr_q.size()) begin
            n_fail++; $display("FAIL %s_count: got %0d writes want %0d", name, obs_wr_q.size(), exp_wr_q.size());
        end
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
            logic [MEM_AW+7:0] e, o;
            e = exp_wr_q.pop_front();
            o = obs_wr_q.pop_front();
            n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL %s_event: got addr/data %h want %h", name, o, e); end
        end
        exp_wr_q.delete();
        obs_wr_q.delete();
    endtask

    task automatic test_write();
        obs_wr_q.delete();
        write_xact(24'h000010, 32'hA53C_0000, 2);
        check_writes("write");
    endtask

    task automatic test_read();
        obs_re_q.delete();
        obs_oe_q.delete();
        exp_nib_q = '{8'hFA, 8'hF5, 8'hF3, 8'hFC};
        exp_re_q  = '{22'h000010, 22'h000011, 22'h000012};
        read_xact(24'h000010, 4);
        n_chk++; if (dummy_leak !== 1'b0) begin n_fail++; $display("FAIL read_dummy_douten: got enabled want 0"); end
        n_chk++; if (post_douten !== 4'h0) begin n_fail++; $display("FAIL read_post_douten: got %h want 0", post_douten); end
        n_chk++; if (obs_nib_q.size() != exp_nib_q.size()) begin n_fail++; $display("FAIL read_nib_count: got %0d want %0d", obs_nib_q.size(), exp_nib_q.size()); end
        while (exp_nib_q.size() > 0 && obs_nib_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_nib_q.pop_front(); o = obs_nib_q.pop_front();
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL read_nibble: got douten/dout %h want %h", o, e); end
        end
        n_chk++; if (obs_re_q.size() != exp_re_q.size()) begin n_fail++; $display("FAIL read_re_count: got %0d want %0d", obs_re_q.size(), exp_re_q.size()); end
        while (exp_re_q.size() > 0 && obs_re_q.size() > 0) begin
            logic [MEM_AW-1:0] e, o;
            e = exp_re_q.pop_front(); o = obs_re_q.pop_front();
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL read_re_addr: got %h want %h", o, e); end
        end
        exp_nib_q.delete(); exp_re_q.delete();
    endtask

    task automatic test_wrap();
        obs_wr_q.delete();
        write_xact(24'h3FFFFF, 32'h1234_5678, 4);
        check_writes("wrap_write");
        obs_re_q.delete();
        exp_nib_q = '{8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'hF8};
        // the last high nibble also prefetches the following byte
        exp_re_q  = '{22'h3FFFFF, 22'h000000, 22'h000001, 22'h000002, 22'h000003};
        read_xact(24'h3FFFFF, 8);
        n_chk++; if (obs_re_q.size() != exp_re_q.size()) begin n_fail++; $display("FAIL wrap_re_count: got %0d want %0d", obs_re_q.size(), exp_re_q.size()); end
        while (exp_re_q.size() > 0 && obs_re_q.size() > 0) begin
            logic [MEM_AW-1:0] e, o;
            e = exp_re_q.pop_front(); o = obs_re_q.pop_front();
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL wrap_re_addr: got %h want %h", o, e); end
        end
        while (exp_nib_q.size() > 0 && obs_nib_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_nib_q.pop_front(); o = obs_nib_q.pop_front();
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL wrap_nibble: got douten/dout %h want %h", o, e); end
        end
        exp_nib_q.delete(); exp_re_q.delete();
    endtask

    task automatic test_abort();
        obs_wr_q.delete();
        cs_begin();
        qpi_byte(CMD_QWRITE);
        send_addr(24'h000020);
        sck_cycle(4'h9);
        cs_end();
        n_chk++; if (obs_wr_q.size() != 0) begin n_fail++; $display("FAIL abort_no_write: got %0d writes want 0", obs_wr_q.size()); end
        write_xact(24'h000020, 32'h5A00_0000, 1);
        check_writes("abort_next");
    endtask

    task automatic test_ignore_and_exit();
        obs_wr_q.delete(); obs_re_q.delete(); obs_oe_q.delete();
        cs_begin();
        qpi_byte(8'h9F);
        for (int i = 0; i < 8; i++) sck_cycle(4'(i + 3));
        cs_end();
        n_chk++; if (obs_wr_q.size() + obs_re_q.size() + obs_oe_q.size() != 0) begin
            n_fail++; $display("FAIL ignore_activity: got %0d events want 0", obs_wr_q.size() + obs_re_q.size() + obs_oe_q.size());
        end
        n_chk++; if (qpi_mode !== 1'b1) begin n_fail++; $display("FAIL ignore_qpi: got %b want 1", qpi_mode); end
        cs_begin();
        qpi_byte(CMD_QPI_EXIT);
        n_chk++; if (qpi_mode !== 1'b1) begin n_fail++; $display("FAIL exit_before_ce: got %b want 1", qpi_mode); end
        cs_end();
        n_chk++; if (qpi_mode !== 1'b0) begin n_fail++; $display("FAIL exit_qpi: got %b want 0", qpi_mode); end
        cs_begin();
        spi_byte(CMD_QPI_EN);
        cs_end();
        n_chk++; if (qpi_mode !== 1'b1) begin n_fail++; $display("FAIL reenter_qpi: got %b want 1", qpi_mode); end
    endtask

    task automatic test_reset_mid();
        cs_begin();
        qpi_byte(CMD_QREAD);
        send_addr(24'h000010);
        for (int d = 0; d < DUMMY_CYCLES + 1; d++) sck_cycle(4'h0);
        n_chk++; if (douten !== 4'hF) begin n_fail++; $display("FAIL mid_read_douten: got %h want F", douten); end
        rst_i = 1'b1;
        #2;
        n_chk++; if (douten !== 4'h0) begin n_fail++; $display("FAIL mid_reset_douten: got %h want 0", douten); end
        n_chk++; if (qpi_mode !== 1'b0) begin n_fail++; $display("FAIL mid_reset_qpi: got %b want 0", qpi_mode); end
        #8;
        ce_n = 1'b1;
        #40 rst_i = 1'b0;
        #40;
        cs_begin();
        spi_byte(CMD_QPI_EN);
        cs_end();
        n_chk++; if (qpi_mode !== 1'b1) begin n_fail++; $display("FAIL post_reset_enter: got %b want 1", qpi_mode); end
        obs_wr_q.delete();
        write_xact(24'h000030, 32'hC300_0000, 1);
        check_writes("post_reset_write");
    endtask

    task automatic test_invariants();
        n_chk++; if (obs_clash_q.size() != 0) begin n_fail++; $display("FAIL re_we_clash: got %0d cycles want 0", obs_clash_q.size()); end
    endtask

    initial begin
        rst_i = 1'b1;
        sck   = 1'b0;
        ce_n  = 1'b1;
        din   = 4'h0;
        #23;
        test_reset();
        rst_i = 1'b0;
        #40;
        test_qpi_enter();
        test_write();
        test_read();
        test_wrap();
        test_abort();
        test_ignore_and_exit();
        test_reset_mid();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
